// File: rtl/sc_psrandom_range.sv
// rtl/sc_psrandom_range.sv - mask-and-reject range sampler feeding a small valid/ready FIFO.
// Optional rejection statistics on reject_Out are built when SC_PSRANDOM_RANGE_STATS_EN is defined.
module sc_psrandom_range #(
   parameter int DATAWIDTH  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int REJ_MAX    = 7
) (
   input  logic                          SC_PSRANDOM_CLOCK_50,
   input  logic                          SC_PSRANDOM_RESET_InHigh,
   input  logic [DATAWIDTH-1:0]          SC_PSRANDOM_data_InBUS,
   input  logic [DATAWIDTH-1:0]          SC_PSRANDOM_limit_InBUS,
   input  logic                          SC_PSRANDOM_flush_InHigh,
   input  logic                          SC_PSRANDOM_ready_InHigh,
   output logic [DATAWIDTH-1:0]          SC_PSRANDOM_data_OutBUS,
   output logic                          SC_PSRANDOM_valid_OutHigh,
   output logic [$clog2(FIFO_DEPTH):0]   SC_PSRANDOM_count_OutBUS,
   output logic [15:0]                   SC_PSRANDOM_reject_OutBUS
);

   localparam int             PW       = $clog2(FIFO_DEPTH);
   localparam logic [PW:0]    FULL_CNT = (PW+1)'(FIFO_DEPTH);
   localparam logic [3:0]     REJ_LAST = 4'(REJ_MAX - 1);

   typedef enum logic [1:0] {ST_FILL, ST_FORCE, ST_HOLD} state_t;

   state_t                 state, state_nxt;
   logic [DATAWIDTH-1:0]   mem [FIFO_DEPTH];
   logic [PW-1:0]          rd_ptr, wr_ptr;
   logic [PW:0]            count, count_nxt;
   logic [3:0]             rej_cnt;

   logic [DATAWIDTH-1:0]   lim_m1, mask, candidate, push_val;
   logic                   cand_ok, full, pop, room, sample, force_cyc, push, trigger;

   // limit-1 wraps to all-ones for limit=0, so the smear yields the pass-through mask for free
   always_comb begin
      lim_m1 = SC_PSRANDOM_limit_InBUS - 1'b1;
      mask   = lim_m1;
      for (int i = 1; i < DATAWIDTH; i++) begin
         mask = mask | (lim_m1 >> i);
      end
      candidate = SC_PSRANDOM_data_InBUS & mask;
      cand_ok   = (SC_PSRANDOM_limit_InBUS == '0) || (candidate < SC_PSRANDOM_limit_InBUS);
   end

   always_ff @(posedge SC_PSRANDOM_CLOCK_50 or posedge SC_PSRANDOM_RESET_InHigh) begin
      if (SC_PSRANDOM_RESET_InHigh) begin
         state <= ST_FILL;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (SC_PSRANDOM_flush_InHigh) begin
         state_nxt = ST_FILL;
      end else if (trigger) begin
         state_nxt = ST_FORCE;
      end else if (force_cyc || sample) begin
         state_nxt = (count_nxt == FULL_CNT) ? ST_HOLD : ST_FILL;
      end
   end

   // A pop frees a slot in the same edge, so a full FIFO that is being drained still samples
   always_comb begin
      full      = (count == FULL_CNT);
      pop       = (count != '0) && SC_PSRANDOM_ready_InHigh;
      room      = !full || pop;
      force_cyc = (state == ST_FORCE);
      sample    = !force_cyc && room;
      push      = room && (force_cyc || (sample && cand_ok));
      push_val  = (force_cyc && !cand_ok) ? (candidate - SC_PSRANDOM_limit_InBUS) : candidate;
      trigger   = sample && !cand_ok && (rej_cnt == REJ_LAST);
      count_nxt = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
   end

   always_ff @(posedge SC_PSRANDOM_CLOCK_50 or posedge SC_PSRANDOM_RESET_InHigh) begin
      if (SC_PSRANDOM_RESET_InHigh) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         rej_cnt <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (SC_PSRANDOM_flush_InHigh) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         rej_cnt <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_val;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_nxt;
         if (force_cyc || (sample && cand_ok)) begin
            rej_cnt <= '0;
         end else if (sample) begin
            rej_cnt <= rej_cnt + 1'b1;
         end
      end
   end

   assign SC_PSRANDOM_data_OutBUS   = mem[rd_ptr];
   assign SC_PSRANDOM_valid_OutHigh = (count != '0);
   assign SC_PSRANDOM_count_OutBUS  = count;

`ifdef SC_PSRANDOM_RANGE_STATS_EN
   logic        rej_event;
   logic [15:0] rej_total;

   assign rej_event = (sample || force_cyc) && !cand_ok;

   always_ff @(posedge SC_PSRANDOM_CLOCK_50 or posedge SC_PSRANDOM_RESET_InHigh) begin
      if (SC_PSRANDOM_RESET_InHigh) begin
         rej_total <= '0;
      end else if (SC_PSRANDOM_flush_InHigh) begin
         rej_total <= '0;
      end else if (rej_event && (rej_total != 16'hFFFF)) begin
         rej_total <= rej_total + 1'b1;
      end
   end

   assign SC_PSRANDOM_reject_OutBUS = rej_total;
`else
   assign SC_PSRANDOM_reject_OutBUS = 16'd0;
`endif

endmodule
